// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg
//   Shared constants and the sequencer state type for nibble_serial_adder.
//   No ports; imported by the top level.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_carry_skip.sv
// carry_skip_adder
//   The 4-bit combinational carry-skip adder used by nibble_serial_adder.
//   Ports:
//     a, b   in   4   addends
//     cin    in   1   carry in
//     sum    out  4   a + b + cin (low 4 bits)
//     carry  out  1   carry out of bit 3
module carry_skip_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum   = p ^ c[3:0];
        // When every bit propagates, the carry in passes straight through
        // the group without waiting on the ripple chain.
        carry = (&p) ? cin : c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands one nibble per cycle (LSB first) through a
//   single carry_skip_adder, registering the carry between nibbles.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous, active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      operands accepted (IDLE only)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into nibble 0
//     out_valid  out  1      sum/cout valid (DONE)
//     out_ready  in   1      consumer accepts result
//     sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//     cout       out  1      carry out of the top nibble
//
//   state  | meaning
//   -------+---------------------------------------------------
//   S_IDLE | waiting for operands, in_ready high
//   S_RUN  | one nibble added per cycle, idx_q selects nibble
//   S_DONE | result held on sum/cout until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               cout_q;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_carry;
    logic                accept;
    logic                last_nib;

    assign nib_a    = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign nib_b    = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign last_nib = (idx_q == LAST_IDX);
    assign accept   = in_valid && in_ready;

    carry_skip_adder u_csa (
        .a     (nib_a),
        .b     (nib_b),
        .cin   (carry_q),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_RUN;
            S_RUN:   if (last_nib)  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // in_ready is held low while rst is asserted so nothing is offered
    // before the block is out of reset.
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_carry;
                    if (last_nib) begin
                        cout_q <= nib_carry;
                        idx_q  <= '0;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
